// File: rtl/edge_event_monitor_pkg.sv
// Shared types and mode decode for the edge_event_monitor slice.
package edge_event_monitor_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        RISE = 2'b01,
        FALL = 2'b10,
        ANY  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PASS,
        FAIL
    } chk_state_e;

    function automatic logic mode_hit(input mode_e m, input logic rise, input logic fall);
        logic hit;
        case (m)
            RISE:    hit = rise;
            FALL:    hit = fall;
            ANY:     hit = rise | fall;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_event_chan.sv
// One monitored channel: two-sample history, validity gating, edge/stable decode,
// sticky flag and saturating event counter. Assertions under EDGE_EVENT_MONITOR_ASSERT_EN.
module edge_event_chan
    import edge_event_monitor_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             edge_o,
    output logic             stable_o,
    output logic             sticky_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic             cur_q;
    logic             prev_q;
    logic [1:0]       vld_q;
    logic             sticky_q;
    logic             sticky_next;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic             vld;
    logic             rise;
    logic             fall;

    // prev_q only holds a real sample once two posedges have passed since reset
    assign vld  = vld_q[1];
    assign rise = cur_q & ~prev_q;
    assign fall = ~cur_q & prev_q;

    always_comb begin
        edge_o      = vld & mode_hit(mode_e'(mode), rise, fall);
        stable_o    = vld & (cur_q == prev_q);
        // clear first, then count the edge seen on the same posedge
        cnt_base    = clr ? '0 : cnt_q;
        cnt_next    = cnt_base;
        if (edge_o && (cnt_base != '1)) begin
            cnt_next = cnt_base + CNT_W'(1);
        end
        sticky_next = (sticky_q & ~clr) | edge_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q    <= 1'b0;
            prev_q   <= 1'b0;
            vld_q    <= 2'b00;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cur_q    <= din;
            prev_q   <= cur_q;
            vld_q    <= {vld_q[0], 1'b1};
            sticky_q <= sticky_next;
            cnt_q    <= cnt_next;
        end
    end

    assign sticky_o = sticky_q;
    assign cnt_o    = cnt_q;

`ifdef EDGE_EVENT_MONITOR_ASSERT_EN
    a_rise_match: assert property (@(posedge clk) disable iff (!rst_n)
        (mode == RISE && vld) |-> (edge_o == $past($rose(din))));
    a_cnt_mono: assert property (@(posedge clk) disable iff (!rst_n)
        !clr |=> (cnt_q >= $past(cnt_q)));
`endif

endmodule

// File: rtl/edge_event_monitor.sv
// Multi-channel sampled-edge monitor with an armable edge-within-window checker.
// Define EDGE_EVENT_MONITOR_ASSERT_EN to compile in the embedded assertions.
module edge_event_monitor
    import edge_event_monitor_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int TO_W  = 8,
    localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic [2*WIDTH-1:0] mode,
    input  logic               clr,
    input  logic               arm,
    input  logic [SEL_W-1:0]   arm_sel,
    input  logic [TO_W-1:0]    timeout_cyc,
    output logic [WIDTH-1:0]   edge_o,
    output logic [WIDTH-1:0]   stable_o,
    output logic [WIDTH-1:0]   sticky_o,
    output logic [WIDTH*CNT_W-1:0] cnt_o,
    output logic               chk_busy,
    output logic               chk_pass,
    output logic               chk_fail
);

    localparam int SEL_N = 1 << SEL_W;

    chk_state_e       state_q, state_next;
    logic [SEL_W-1:0] sel_q, sel_next;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_next;
    logic [SEL_N-1:0] edge_pad;
    logic             sel_edge;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        edge_event_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .din      (din[gi]),
            .mode     (mode[2*gi +: 2]),
            .clr      (clr),
            .edge_o   (edge_o[gi]),
            .stable_o (stable_o[gi]),
            .sticky_o (sticky_o[gi]),
            .cnt_o    (cnt_o[gi*CNT_W +: CNT_W])
        );
    end

    // selections at or beyond WIDTH land on zero padding and never qualify
    assign edge_pad = SEL_N'(edge_o);
    assign sel_edge = edge_pad[sel_q];

    always_comb begin
        state_next  = state_q;
        sel_next    = sel_q;
        to_cnt_next = to_cnt_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_next  = WAIT;
                    sel_next    = arm_sel;
                    to_cnt_next = timeout_cyc;
                end
            end
            WAIT: begin
                if (sel_edge) begin
                    state_next = PASS;
                end else if (to_cnt_q == '0) begin
                    state_next = FAIL;
                end else begin
                    to_cnt_next = to_cnt_q - TO_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_next;
            sel_q    <= sel_next;
            to_cnt_q <= to_cnt_next;
        end
    end

    assign chk_busy = (state_q == WAIT);
    assign chk_pass = (state_q == PASS);
    assign chk_fail = (state_q == FAIL);

`ifdef EDGE_EVENT_MONITOR_ASSERT_EN
    a_verdict_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(chk_pass && chk_fail));
    a_busy_wait: assert property (@(posedge clk) disable iff (!rst_n)
        chk_busy |-> (state_q == WAIT));
`endif

endmodule

// File: tb/tb_edge_event_monitor.sv
// Directed scenarios plus randomized traffic for edge_event_monitor, checked
// against a sample-history reference model.
module tb_edge_event_monitor;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;
    localparam int TO_W  = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic [WIDTH-1:0]   din;
    logic [2*WIDTH-1:0] mode;
    logic               clr;
    logic               arm;
    logic [1:0]         arm_sel;
    logic [TO_W-1:0]    timeout_cyc;
    logic [WIDTH-1:0]   edge_o;
    logic [WIDTH-1:0]   stable_o;
    logic [WIDTH-1:0]   sticky_o;
    logic [WIDTH*CNT_W-1:0] cnt_o;
    logic               chk_busy;
    logic               chk_pass;
    logic               chk_fail;

    edge_event_monitor #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .TO_W  (TO_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .mode        (mode),
        .clr         (clr),
        .arm         (arm),
        .arm_sel     (arm_sel),
        .timeout_cyc (timeout_cyc),
        .edge_o      (edge_o),
        .stable_o    (stable_o),
        .sticky_o    (sticky_o),
        .cnt_o       (cnt_o),
        .chk_busy    (chk_busy),
        .chk_pass    (chk_pass),
        .chk_fail    (chk_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: samples taken since reset, event totals, checker window bookkeeping.
    logic [WIDTH-1:0] hist[$];
    int  m_cnt[WIDTH];
    bit  m_sticky[WIDTH];
    bit  m_busy;
    int  m_sel;
    int  m_deadline;
    int  m_idle_from;
    int  m_verdict_cyc;
    bit  m_verdict_pass;
    int  cyc;

    function automatic logic [WIDTH-1:0] model_edges();
        logic [WIDTH-1:0] e = '0;
        if (hist.size() == 2) begin
            for (int i = 0; i < WIDTH; i++) begin
                bit now_v  = hist[1][i];
                bit then_v = hist[0][i];
                int m = int'(mode[2*i +: 2]);
                bit up = now_v && !then_v;
                bit dn = !now_v && then_v;
                e[i] = (m == 1) ? up : (m == 2) ? dn : (m == 3) ? (up || dn) : 1'b0;
            end
        end
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] model_stable();
        logic [WIDTH-1:0] s = '0;
        if (hist.size() == 2) s = ~(hist[1] ^ hist[0]);
        return s;
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < WIDTH; i++) begin
            m_cnt[i]    = 0;
            m_sticky[i] = 0;
        end
        m_busy         = 0;
        m_idle_from    = 0;
        m_verdict_cyc  = -100;
        m_verdict_pass = 0;
        cyc            = 0;
    endfunction

    function automatic void model_clock();
        logic [WIDTH-1:0] e = model_edges();
        for (int i = 0; i < WIDTH; i++) begin
            if (clr) begin
                m_cnt[i]    = 0;
                m_sticky[i] = 0;
            end
            if (e[i]) begin
                m_cnt[i]    = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                m_sticky[i] = 1;
            end
        end
        cyc++;
        if (m_busy) begin
            if (m_sel < WIDTH && e[m_sel]) begin
                m_busy = 0; m_verdict_cyc = cyc; m_verdict_pass = 1; m_idle_from = cyc + 2;
            end else if (cyc == m_deadline) begin
                m_busy = 0; m_verdict_cyc = cyc; m_verdict_pass = 0; m_idle_from = cyc + 2;
            end
        end else if (arm && cyc >= m_idle_from) begin
            m_busy     = 1;
            m_sel      = int'(arm_sel);
            m_deadline = cyc + 1 + int'(timeout_cyc);
        end
        hist.push_back(din);
        if (hist.size() > 2) void'(hist.pop_front());
    endfunction

    task automatic check_outputs();
        logic [WIDTH-1:0] st = '0;
        for (int i = 0; i < WIDTH; i++) st[i] = m_sticky[i];
        chk_eq("edge_o", 32'(edge_o), 32'(model_edges()));
        chk_eq("stable_o", 32'(stable_o), 32'(model_stable()));
        chk_eq("sticky_o", 32'(sticky_o), 32'(st));
        for (int i = 0; i < WIDTH; i++)
            chk_eq($sformatf("cnt%0d", i), 32'(cnt_o[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
        chk_eq("chk_busy", 32'(chk_busy), 32'(m_busy));
        chk_eq("chk_pass", 32'(chk_pass), 32'(m_verdict_cyc == cyc && m_verdict_pass));
        chk_eq("chk_fail", 32'(chk_fail), 32'(m_verdict_cyc == cyc && !m_verdict_pass));
    endtask

    // Inputs are driven 1 ns after a posedge; this checks mid-cycle, then advances one clock.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_eq("rst_busy", 32'(chk_busy), 0);
        chk_eq("rst_pass", 32'(chk_pass), 0);
        chk_eq("rst_fail", 32'(chk_fail), 0);
        chk_eq("rst_cnt", 32'(cnt_o), 0);
        chk_eq("rst_edge", 32'(edge_o), 0);
        chk_eq("rst_sticky", 32'(sticky_o), 0);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; din = 4'hF; mode = 8'h55; clr = 1'b0;
        arm = 1'b0; arm_sel = '0; timeout_cyc = '0;
        model_reset();
        #12;
        chk_eq("init_busy", 32'(chk_busy), 0);
        chk_eq("init_edge", 32'(edge_o), 0);
        chk_eq("init_stable", 32'(stable_o), 0);
        chk_eq("init_cnt", 32'(cnt_o), 0);
        rst_n = 1'b1;

        // all-high input out of reset must not look like a rising edge
        repeat (5) cycle();
        chk_eq("rel_cnt", 32'(cnt_o), 0);
        chk_eq("rel_sticky", 32'(sticky_o), 0);

        // rise/fall/any/off on ch0..ch3 with identical stimulus
        mode = 8'b00_11_10_01;
        din  = 4'h0;
        repeat (3) cycle();
        clr = 1'b1; cycle(); clr = 1'b0;
        din = 4'b0111; cycle();
        din = 4'b0000; cycle();
        din = 4'b0111; cycle();
        repeat (3) cycle();
        chk_eq("tog_cnt_rise", 32'(cnt_o[0 +: CNT_W]), 2);
        chk_eq("tog_cnt_fall", 32'(cnt_o[CNT_W +: CNT_W]), 1);
        chk_eq("tog_cnt_any", 32'(cnt_o[2*CNT_W +: CNT_W]), 3);
        chk_eq("tog_cnt_off", 32'(cnt_o[3*CNT_W +: CNT_W]), 0);

        // saturation on ch1, then clear coinciding with an edge
        mode = 8'h55; din = 4'h0;
        clr = 1'b1; cycle(); clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            din[1] = 1'b1; cycle();
            din[1] = 1'b0; cycle();
        end
        repeat (2) cycle();
        chk_eq("sat_cnt", 32'(cnt_o[CNT_W +: CNT_W]), CMAX);
        chk_eq("sat_sticky", 32'(sticky_o[1]), 1);
        din[1] = 1'b1; cycle();
        clr = 1'b1; cycle(); clr = 1'b0;
        chk_eq("clr_edge_cnt", 32'(cnt_o[CNT_W +: CNT_W]), 1);
        chk_eq("clr_edge_sticky", 32'(sticky_o[1]), 1);

        // checker pass: rise on ch2 during the third WAIT cycle
        din = 4'h0; repeat (2) cycle();
        arm = 1'b1; arm_sel = 2'd2; timeout_cyc = 8'd3; cycle();
        arm = 1'b0; cycle();
        din[2] = 1'b1; cycle();
        cycle();
        chk_eq("dir_pass", 32'(chk_pass), 1);
        chk_eq("dir_pass_nofail", 32'(chk_fail), 0);
        cycle();

        // checker fail with zero timeout; re-arm during FAIL is ignored
        arm = 1'b1; arm_sel = 2'd0; timeout_cyc = 8'd0; cycle();
        arm = 1'b0; cycle();
        chk_eq("dir_fail", 32'(chk_fail), 1);
        arm = 1'b1; cycle();
        arm = 1'b0;
        chk_eq("rearm_busy", 32'(chk_busy), 0);
        cycle();
        chk_eq("rearm_idle", 32'(chk_busy), 0);

        // reset in the middle of a long window
        arm = 1'b1; arm_sel = 2'd3; timeout_cyc = 8'd200; cycle();
        arm = 1'b0; repeat (3) cycle();
        chk_eq("wait_busy", 32'(chk_busy), 1);
        do_reset();
        repeat (3) cycle();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            for (int i = 0; i < WIDTH; i++)
                if ($urandom_range(0, 2) == 0) din[i] = ~din[i];
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
            clr         = ($urandom_range(0, 19) == 0);
            arm         = ($urandom_range(0, 3) == 0);
            arm_sel     = 2'($urandom_range(0, 3));
            timeout_cyc = 8'($urandom_range(0, 6));
            cycle();
        end
        #1;
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/edge_event_monitor.md
# edge_event_monitor

Parametrised multi-channel sampled-edge monitor: synthesizable RTL equivalent of the `$rose`/`$fell`/`$stable` sampled-value functions evaluated on `posedge clk`, for WIDTH independent channels. Each channel has a per-channel edge mode, a one-cycle edge pulse, a sticky flag and a saturating event counter. A single armable checker tests whether a qualifying edge occurs on a selected channel within a programmable cycle window. It sits beside DUT signals in simulation benches and on-chip as a debug/event monitor.

## Interface
- `WIDTH`, 4: number of monitored channels (1..32)
- `CNT_W`, 8: event counter width per channel
- `TO_W`, 8: checker timeout width
- `clk` in 1: sole clock; all sampling on rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `din` in WIDTH: monitored signals, sampled each posedge
- `mode` in 2*WIDTH: per-channel mode, bits [2i+1:2i]; 00 off, 01 rise, 10 fall, 11 any
- `clr` in 1: synchronous clear of all sticky flags and counters
- `arm` in 1: start checker (accepted only in IDLE)
- `arm_sel` in $clog2(WIDTH) (min 1): checker channel, captured with `arm`
- `timeout_cyc` in TO_W: checker window length, captured with `arm`
- `edge_o` out WIDTH: qualifying-edge pulse per channel
- `stable_o` out WIDTH: current sample equals previous sample
- `sticky_o` out WIDTH: edge seen since last clear
- `cnt_o` out WIDTH*CNT_W: saturating edge counts, channel i at [i*CNT_W +: CNT_W]
- `chk_busy` out 1: checker in WAIT
- `chk_pass` / `chk_fail` out 1: one-cycle checker verdicts

## Operation
- Per channel: `cur_q <= din[i]`, `prev_q <= cur_q` every posedge. `rise = cur_q & ~prev_q`, `fall = ~cur_q & prev_q`.
- `vld_q[1:0]` shifts in 1 after reset; `edge_o`/`stable_o` forced 0 until both history bits are valid, i.e. for the first two posedges after reset. There is no false edge from reset history.
- `edge_o[i]` = rise (mode 01), fall (10), rise|fall (11), 0 (00). Mode changes take effect combinationally.
- `stable_o[i] = (cur_q == prev_q) & vld`. It is independent of mode.
- On each posedge where `edge_o[i]`=1: `sticky_o[i]` <= 1; `cnt` increments and saturates at 2^CNT_W-1.
- `clr` together with an edge on the same posedge: clear is applied first, then the edge, so the result is cnt=1, sticky=1.
- Checker FSM, enum IDLE/WAIT/PASS/FAIL:
  - IDLE: when `arm`=1, capture sel and timeout into `to_cnt`, go to WAIT.
  - WAIT: if `edge_o[sel_q]`, go to PASS. Else if `to_cnt`==0, go to FAIL. Else decrement `to_cnt`.
  - PASS and FAIL last one cycle, then return to IDLE. `arm` outside IDLE is ignored.
  - `arm_sel` ≥ WIDTH fails at window end, because that edge never qualifies.
- The window is timeout_cyc+1 cycles. timeout_cyc=0 means only the first WAIT cycle counts.

## Timing
- Reset values: all history, vld, sticky, cnt = 0; FSM = IDLE; every output = 0.
- Edge latency: a `din` change first sampled at posedge t gives `edge_o` high from after t to posedge t+1, i.e. one cycle, matching `$rose` at t.
- Sticky and cnt are visible one cycle after `edge_o`.
- Arm at posedge t puts the FSM in WAIT from t. An edge on `edge_o` in the cycle after t passes at posedge t+1, and `chk_pass` is high in the following cycle.
- `rst_n` low mid-WAIT aborts immediately with no verdict pulse.

## Configuration
- `EDGE_EVENT_MONITOR_ASSERT_EN` defined: embedded concurrent assertions are compiled in:
  - `edge_o[i]` in rise mode ⇔ `$rose(din[i])` one cycle earlier, after vld.
  - `chk_pass` and `chk_fail` are never both high.
  - `chk_busy` implies FSM is in WAIT.
  - cnt never decreases except on `clr`.
- Macro undefined: no assertions are compiled in, and RTL behaviour is identical.

## Structure
- `edge_event_monitor_pkg`: `mode_e` (OFF/RISE/FALL/ANY), `chk_state_e`, mode-decode function.
- Sub-module `edge_event_chan`: history, vld gating, edge/stable decode, sticky, counter. It is generate-instantiated WIDTH times. The checker FSM lives in the top.

## Test plan
- Reset release with din=4'b1111, mode all 01 → no `edge_o` during the first two posedges; `edge_o`=0 thereafter, cnt=0.
- din toggles ch0 0→1→0→1 every 10 ns, clk period 10, modes 01/10/11 on ch0/1/2 with the same stimulus → rise/fall/any pulses; after 3 toggles cnt ch0 (rise)=2, ch2 (any)=3.
- CNT_W=2, 5 rising edges on ch1 → cnt saturates at 3 and sticky=1; then `clr` on the same posedge as an edge → cnt=1, sticky=1.
- Arm sel=2, timeout=3, rise on ch2 at the 3rd WAIT cycle → `chk_pass` one cycle, `chk_fail`=0.
- Arm sel=0, timeout=0, no edge → `chk_fail` two cycles after arm. A second `arm` during FAIL is ignored.
- `rst_n` pulsed low in WAIT → `chk_busy`, `chk_pass`, `chk_fail` all 0 immediately, counters 0.
